// File: rtl/feature_fifo_fwft_mc.sv
// Multi-channel first-word-fall-through feature FIFO with frame replay.
// The read side is a sync-read RAM stage plus one output register, with base/rewind/release frame pointers.
module feature_fifo_fwft_mc #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned DEPTH    = 729,
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [CHANNELS*DATA_W-1:0]   wr_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [CHANNELS*DATA_W-1:0]   rd_data,
    input  logic                         rewind,
    input  logic                         release_base,
    output logic [CNT_W-1:0]             occupancy,
    output logic [CNT_W-1:0]             unread,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned W  = CHANNELS * DATA_W;
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [AW-1:0] ptr_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    logic [W-1:0]     mem [DEPTH];
    logic [W-1:0]     a_data;
    logic             a_valid;
    ptr_t             wr_ptr, base_ptr, rd_ptr, fetch_ptr;
    logic [CNT_W-1:0] pend;

    logic             wr_acc, pop, release_eff, out_load, fetch;
    ptr_t             wr_ptr_n, base_n, rd_ptr_adv, rd_ptr_n, fetch_n;
    logic [CNT_W-1:0] occ_n, unread_n, pend_n;
    logic             a_valid_n, rd_valid_n;

    // Next-state: pend counts words written but not yet fetched into the RAM read stage.
    always_comb begin
        wr_acc      = wr_valid && wr_ready;
        pop         = rd_valid && rd_ready && !rewind;
        release_eff = release_base && !rewind;
        out_load    = !rd_valid || pop;
        fetch       = !rewind && (pend != '0) && (!a_valid || out_load);

        wr_ptr_n    = wr_acc ? ptr_inc(wr_ptr) : wr_ptr;
        rd_ptr_adv  = pop ? ptr_inc(rd_ptr) : rd_ptr;
        base_n      = base_ptr;
        rd_ptr_n    = rd_ptr_adv;
        fetch_n     = fetch ? ptr_inc(fetch_ptr) : fetch_ptr;
        occ_n       = occupancy + CNT_W'(wr_acc);
        unread_n    = unread - CNT_W'(pop) + CNT_W'(wr_acc);
        pend_n      = pend - CNT_W'(fetch) + CNT_W'(wr_acc);
        a_valid_n   = fetch ? 1'b1 : (out_load ? 1'b0 : a_valid);
        rd_valid_n  = out_load ? a_valid : rd_valid;

        if (rewind) begin
            rd_ptr_n   = base_ptr;
            fetch_n    = base_ptr;
            unread_n   = occ_n;
            pend_n     = occ_n;
            a_valid_n  = 1'b0;
            rd_valid_n = 1'b0;
        end else if (release_eff) begin
            // Freed words are everything before the first unconsumed word.
            base_n = rd_ptr_adv;
            occ_n  = unread_n;
        end
    end

    // RAM with registered read port; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
        if (fetch) begin
            a_data <= mem[fetch_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            base_ptr  <= '0;
            rd_ptr    <= '0;
            fetch_ptr <= '0;
            pend      <= '0;
            a_valid   <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            occupancy <= '0;
            unread    <= '0;
            full      <= 1'b0;
            wr_ready  <= 1'b1;
            empty     <= 1'b1;
        end else begin
            wr_ptr    <= wr_ptr_n;
            base_ptr  <= base_n;
            rd_ptr    <= rd_ptr_n;
            fetch_ptr <= fetch_n;
            pend      <= pend_n;
            a_valid   <= a_valid_n;
            rd_valid  <= rd_valid_n;
            if (!rewind && out_load && a_valid) begin
                rd_data <= a_data;
            end
            occupancy <= occ_n;
            unread    <= unread_n;
            full      <= (occ_n == CNT_W'(DEPTH));
            wr_ready  <= (occ_n != CNT_W'(DEPTH));
            empty     <= (unread_n == '0) && !rd_valid_n;
        end
    end

endmodule

// File: tb/tb_feature_fifo_fwft_mc.sv
// Bench for feature_fifo_fwft_mc: a 3-lane/729-deep instance for directed frame tests,
// and a 1-lane/5-deep instance run against a queue-based reference model.
module tb_feature_fifo_fwft_mc;

    localparam int unsigned BW   = 24;
    localparam int unsigned B_CW = 10;
    localparam int unsigned S_CW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            b_rst, b_wr_valid, b_wr_ready, b_rd_valid, b_rd_ready, b_rewind, b_release;
    logic            b_full, b_empty;
    logic [BW-1:0]   b_wr_data, b_rd_data;
    logic [B_CW-1:0] b_occ, b_unread;

    logic            s_rst, s_wr_valid, s_wr_ready, s_rd_valid, s_rd_ready, s_rewind, s_release;
    logic            s_full, s_empty;
    logic [7:0]      s_wr_data, s_rd_data;
    logic [S_CW-1:0] s_occ, s_unread;

    feature_fifo_fwft_mc #(.DATA_W(8), .CHANNELS(3), .DEPTH(729)) u_big (
        .clk(clk), .rst(b_rst), .wr_valid(b_wr_valid), .wr_ready(b_wr_ready),
        .wr_data(b_wr_data), .rd_valid(b_rd_valid), .rd_ready(b_rd_ready),
        .rd_data(b_rd_data), .rewind(b_rewind), .release_base(b_release),
        .occupancy(b_occ), .unread(b_unread), .full(b_full), .empty(b_empty)
    );

    feature_fifo_fwft_mc #(.DATA_W(8), .CHANNELS(1), .DEPTH(5)) u_small (
        .clk(clk), .rst(s_rst), .wr_valid(s_wr_valid), .wr_ready(s_wr_ready),
        .wr_data(s_wr_data), .rd_valid(s_rd_valid), .rd_ready(s_rd_ready),
        .rd_data(s_rd_data), .rewind(s_rewind), .release_base(s_release),
        .occupancy(s_occ), .unread(s_unread), .full(s_full), .empty(s_empty)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [23:0] data;
        logic        rel;
        logic        e_valid;
        logic [23:0] e_data;
        logic        e_empty;
        logic [9:0]  e_occ;
        logic [9:0]  e_unread;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic [23:0] d, input logic rel,
                                input logic ev, input logic [23:0] ed, input logic ee,
                                input logic [9:0] eo, input logic [9:0] eu);
        vec_t v;
        v.wr = wr; v.data = d; v.rel = rel; v.e_valid = ev; v.e_data = ed;
        v.e_empty = ee; v.e_occ = eo; v.e_unread = eu;
        return v;
    endfunction

    task automatic b_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic b_idle();
        b_wr_valid = 1'b0; b_rd_ready = 1'b0; b_rewind = 1'b0; b_release = 1'b0;
    endtask

    task automatic b_wait_valid(input string name);
        int n = 0;
        while (!b_rd_valid && n < 10) begin
            b_step();
            n++;
        end
        check(name, 32'(b_rd_valid), 32'd1);
    endtask

    // Streams n pops with rd_ready held high; expects consecutive words starting at 'first'.
    task automatic b_drain(input int n, input int first, input string name);
        int got = 0;
        int budget = 0;
        b_rd_ready = 1'b1;
        while (got < n && budget < n + 20) begin
            if (b_rd_valid) begin
                check(name, 32'(b_rd_data), 32'(first + got));
                got++;
            end
            b_step();
            budget++;
        end
        b_rd_ready = 1'b0;
        check({name, "_count"}, 32'(got), 32'(n));
    endtask

    vec_t tbl[11];
    logic [7:0] sq[$];

    initial begin
        int ridx;
        int pops;
        int got;
        int budget;

        b_idle(); b_rst = 1'b1; b_wr_data = '0;
        s_rst = 1'b1; s_wr_valid = 1'b0; s_rd_ready = 1'b0; s_rewind = 1'b0;
        s_release = 1'b0; s_wr_data = '0;

        tbl[0]  = mk(1'b0, 24'h0,      1'b0, 1'b0, 24'h0,      1'b1, 10'd0, 10'd0);
        tbl[1]  = mk(1'b1, 24'h010203, 1'b0, 1'b0, 24'h0,      1'b0, 10'd1, 10'd1);
        tbl[2]  = mk(1'b0, 24'h0,      1'b0, 1'b0, 24'h0,      1'b0, 10'd1, 10'd1);
        tbl[3]  = mk(1'b0, 24'h0,      1'b0, 1'b1, 24'h010203, 1'b0, 10'd1, 10'd1);
        tbl[4]  = mk(1'b0, 24'h0,      1'b0, 1'b0, 24'h0,      1'b1, 10'd1, 10'd0);
        tbl[5]  = mk(1'b1, 24'h0A0B0C, 1'b0, 1'b0, 24'h0,      1'b0, 10'd2, 10'd1);
        tbl[6]  = mk(1'b1, 24'h0D0E0F, 1'b0, 1'b0, 24'h0,      1'b0, 10'd3, 10'd2);
        tbl[7]  = mk(1'b0, 24'h0,      1'b0, 1'b1, 24'h0A0B0C, 1'b0, 10'd3, 10'd2);
        tbl[8]  = mk(1'b0, 24'h0,      1'b0, 1'b1, 24'h0D0E0F, 1'b0, 10'd3, 10'd1);
        tbl[9]  = mk(1'b0, 24'h0,      1'b0, 1'b0, 24'h0,      1'b1, 10'd3, 10'd0);
        tbl[10] = mk(1'b0, 24'h0,      1'b1, 1'b0, 24'h0,      1'b1, 10'd0, 10'd0);

        @(negedge clk);
        b_step(); b_step();
        check("rst_rd_valid", 32'(b_rd_valid), 32'd0);
        check("rst_rd_data",  32'(b_rd_data),  32'd0);
        check("rst_wr_ready", 32'(b_wr_ready), 32'd1);
        check("rst_occ",      32'(b_occ),      32'd0);
        check("rst_unread",   32'(b_unread),   32'd0);
        check("rst_full",     32'(b_full),     32'd0);
        check("rst_empty",    32'(b_empty),    32'd1);
        b_rst = 1'b0;

        // Fall-through latency, back-to-back pops, and release, one edge per row.
        for (int i = 0; i < 11; i++) begin
            b_wr_valid = tbl[i].wr; b_wr_data = tbl[i].data;
            b_rd_ready = 1'b1;      b_release = tbl[i].rel;
            b_step();
            check($sformatf("t1_valid[%0d]", i), 32'(b_rd_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid)
                check($sformatf("t1_data[%0d]", i), 32'(b_rd_data), 32'(tbl[i].e_data));
            check($sformatf("t1_empty[%0d]", i),  32'(b_empty),  32'(tbl[i].e_empty));
            check($sformatf("t1_occ[%0d]", i),    32'(b_occ),    32'(tbl[i].e_occ));
            check($sformatf("t1_unread[%0d]", i), 32'(b_unread), 32'(tbl[i].e_unread));
        end
        b_idle();

        b_rst = 1'b1; b_step(); b_rst = 1'b0;

        // Fill to full, then a dropped write, then drain in order.
        for (int i = 0; i < 729; i++) begin
            b_wr_valid = 1'b1; b_wr_data = 24'(i);
            b_step();
        end
        b_wr_valid = 1'b0;
        check("t2_full",     32'(b_full),     32'd1);
        check("t2_wr_ready", 32'(b_wr_ready), 32'd0);
        check("t2_occ",      32'(b_occ),      32'd729);
        b_wr_valid = 1'b1; b_wr_data = 24'hABCDEF;
        b_step();
        b_wr_valid = 1'b0;
        check("t2_drop_occ", 32'(b_occ), 32'd729);
        b_drain(729, 0, "t2_drain");
        check("t2_empty",  32'(b_empty),  32'd1);
        check("t2_occ_kept", 32'(b_occ),  32'd729);

        // Rewind a full frame: two-cycle bubble, then the whole map again.
        b_rewind = 1'b1; b_step(); b_rewind = 1'b0;
        check("t3_flush0", 32'(b_rd_valid), 32'd0);
        check("t3_unread", 32'(b_unread),   32'd729);
        b_step();
        check("t3_flush1", 32'(b_rd_valid), 32'd0);
        b_step();
        check("t3_valid",  32'(b_rd_valid), 32'd1);
        check("t3_head",   32'(b_rd_data),  32'd0);
        b_drain(729, 0, "t3_reread");
        check("t3_occ", 32'(b_occ), 32'd729);

        // Consume 100 words, release them, refill across the address wrap.
        b_rewind = 1'b1; b_step(); b_rewind = 1'b0;
        got = 0; budget = 0;
        while (got < 100 && budget < 200) begin
            if (b_rd_valid) begin
                check("t4_pop", 32'(b_rd_data), 32'(got));
                b_rd_ready = 1'b1;
                got++;
            end else begin
                b_rd_ready = 1'b0;
            end
            b_step();
            budget++;
        end
        b_rd_ready = 1'b0;
        check("t4_pop_count", 32'(got), 32'd100);
        check("t4_pre_wr_ready", 32'(b_wr_ready), 32'd0);
        b_release = 1'b1; b_step(); b_release = 1'b0;
        check("t4_occ",      32'(b_occ),      32'd629);
        check("t4_wr_ready", 32'(b_wr_ready), 32'd1);
        check("t4_full",     32'(b_full),     32'd0);
        check("t4_head",     32'(b_rd_data),  32'd100);
        for (int j = 0; j < 100; j++) begin
            b_wr_valid = 1'b1; b_wr_data = 24'(729 + j);
            b_step();
        end
        b_wr_valid = 1'b0;
        check("t4_refill_occ", 32'(b_occ), 32'd729);
        check("t4_head_held",  32'(b_rd_data), 32'd100);
        b_drain(729, 100, "t4_wrap_read");

        // rewind+release with a live pop handshake: only the rewind takes effect.
        b_rewind = 1'b1; b_step(); b_rewind = 1'b0;
        b_wait_valid("t5_wait0");
        b_rd_ready = 1'b1; b_rewind = 1'b1; b_release = 1'b1;
        b_step();
        b_idle();
        check("t5_flush",  32'(b_rd_valid), 32'd0);
        check("t5_occ",    32'(b_occ),      32'd729);
        check("t5_unread", 32'(b_unread),   32'd729);
        b_wait_valid("t5_wait1");
        check("t5_head", 32'(b_rd_data), 32'd100);

        // Random traffic on the 5-deep instance against the reference queue.
        ridx = 0; pops = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic pop, wacc;
            check("s_occ",      32'(s_occ),      32'(sq.size()));
            check("s_unread",   32'(s_unread),   32'(sq.size() - ridx));
            check("s_full",     32'(s_full),     32'(sq.size() == 5));
            check("s_wr_ready", 32'(s_wr_ready), 32'(sq.size() != 5));
            check("s_empty",    32'(s_empty),    32'(sq.size() == ridx));
            if (sq.size() == ridx)
                check("s_valid_idle", 32'(s_rd_valid), 32'd0);
            if (cyc == 5001)
                check("s_rst_data", 32'(s_rd_data), 32'd0);

            if (cyc == 5000) begin
                s_rst = 1'b1; s_wr_valid = 1'b0; s_rd_ready = 1'b0;
                s_rewind = 1'b0; s_release = 1'b0;
            end else begin
                s_rst = 1'b0;
                s_wr_valid = 1'($urandom_range(0, 1));
                s_wr_data  = 8'($urandom);
                s_rd_ready = 1'($urandom_range(0, 1));
                s_rewind   = 1'($urandom_range(0, 1));
                s_release  = 1'($urandom_range(0, 1));
            end

            pop  = s_rd_valid && s_rd_ready;
            wacc = s_wr_valid && (sq.size() < 5);
            if (s_rst) begin
                sq.delete();
                ridx = 0;
            end else begin
                if (s_rewind) begin
                    ridx = 0;
                end else begin
                    if (pop) begin
                        check("s_pop_avail", 32'(ridx < sq.size()), 32'd1);
                        if (ridx < sq.size())
                            check("s_data", 32'(s_rd_data), 32'(sq[ridx]));
                        ridx++;
                        pops++;
                    end
                    if (s_release) begin
                        repeat (ridx) void'(sq.pop_front());
                        ridx = 0;
                    end
                end
                if (wacc) sq.push_back(s_wr_data);
            end
            @(posedge clk);
            @(negedge clk);
        end
        check("s_pops_seen", 32'(pops > 100), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
